idli_pred_ctrl_m: RTL and testbench

Sequences the predicate register file for the nibble-serial core. It performs the serial 16-bit compare, 4 bits per cycle LSB-first, and issues the single predicate write. It also owns the predicate read port and produces the execute/skip decision for the instruction in flight. It sits between decode/ALU operand nibbles and the predicate register file.

---
 rtl/idli_pkg.sv | 34 +++
 rtl/idli_serial_cmp_m.sv | 58 +++++
 rtl/idli_pred_ctrl_m.sv | 165 ++++++++++++++++
 tb/tb_idli_pred_ctrl_m.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types for the idli nibble-serial core.
//   preg_t       : predicate register select; PREG_PT always reads as true
//   cmp_op_t     : compare operation encoding for the predicate unit
//   pred_state_t : sequencing states of the predicate controller
//   NIB_W        : datapath width, one operand nibble
package idli_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        PREG_P0 = 2'd0,
        PREG_P1 = 2'd1,
        PREG_P2 = 2'd2,
        PREG_PT = 2'd3
    } preg_t;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'd0,
        CMP_NE   = 3'd1,
        CMP_LTU  = 3'd2,
        CMP_GEU  = 3'd3,
        CMP_LT   = 3'd4,
        CMP_GE   = 3'd5,
        CMP_RSV6 = 3'd6,
        CMP_RSV7 = 3'd7
    } cmp_op_t;

    typedef enum logic [1:0] {
        PC_IDLE = 2'd0,
        PC_CMP  = 2'd1,
        PC_WB   = 2'd2
    } pred_state_t;

endpackage

// File: rtl/idli_serial_cmp_m.sv
// Nibble-serial A-B subtractor with equality accumulation, LSB nibble first.
// Outputs are combinational for the nibble currently presented, folded with
// the accumulated state from earlier nibbles of the same compare.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : a nibble is consumed this cycle
//   first        : this nibble is nibble 0 (borrow-in 0, equality restarts)
//   last         : this nibble is the final one (accumulators return to idle)
//   a, b         : operand nibbles
//   eq           : all nibbles so far, including this one, equal
//   borrow       : borrow out of this nibble
//   sign         : top bit of this nibble's difference
//   ovf          : signed overflow of A-B if this is the top nibble
module idli_serial_cmp_m
    import idli_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             first,
    input  logic             last,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic             eq,
    output logic             borrow,
    output logic             sign,
    output logic             ovf
);

    logic             eq_acc;
    logic             borrow_acc;
    logic             borrow_in;
    logic [NIB_W:0]   diff;

    always_comb begin
        borrow_in = first ? 1'b0 : borrow_acc;
        diff      = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, borrow_in};
        eq        = (a == b) && (first || eq_acc);
        borrow    = diff[NIB_W];
        sign      = diff[NIB_W-1];
        ovf       = (a[NIB_W-1] ^ b[NIB_W-1]) & (a[NIB_W-1] ^ diff[NIB_W-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_acc     <= 1'b0;
            borrow_acc <= 1'b0;
        end else if (en) begin
            if (last) begin
                eq_acc     <= 1'b0;
                borrow_acc <= 1'b0;
            end else begin
                eq_acc     <= eq;
                borrow_acc <= borrow;
            end
        end
    end

endmodule

// File: rtl/idli_pred_ctrl_m.sv
// Predicate controller: runs the serial 16-bit compare, issues the single
// predicate write, and drives the predicate read port / execute decision.
//   i_pred_gck, i_pred_rst          : clock, asynchronous active-high reset
//   i_cmp_start/op/dst/a/b          : compare launch, op, destination, nibbles
//   i_flush                         : abandon an in-progress compare
//   i_instr_pred, i_instr_inv       : guard of the instruction in flight
//   o_exec                          : guard result (read data XOR invert)
//   o_busy                          : compare sequence active
//   o_pred_rd, i_pred_rd_data       : predicate file read port
//   o_pred_wr/_wr_en/_wr_data       : predicate file write port (registered)
module idli_pred_ctrl_m
    import idli_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic             i_pred_gck,
    input  logic             i_pred_rst,
    input  logic             i_cmp_start,
    input  cmp_op_t          i_cmp_op,
    input  preg_t            i_cmp_dst,
    input  logic [NIB_W-1:0] i_cmp_a,
    input  logic [NIB_W-1:0] i_cmp_b,
    input  logic             i_flush,
    input  preg_t            i_instr_pred,
    input  logic             i_instr_inv,
    output logic             o_exec,
    output logic             o_busy,
    output preg_t            o_pred_rd,
    input  logic             i_pred_rd_data,
    output preg_t            o_pred_wr,
    output logic             o_pred_wr_en,
    output logic             o_pred_wr_data
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    pred_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmp_op_t          op_q, op_d;
    preg_t            dst_q, dst_d;
    logic             wr_en_q, wr_en_d;
    logic             wr_data_q, wr_data_d;

    logic cmp_en, cmp_first, cmp_last;
    logic cmp_eq, cmp_borrow, cmp_sign, cmp_ovf;
    logic launch;

    function automatic logic cmp_result(input cmp_op_t op, input logic eq,
                                        input logic borrow, input logic sign,
                                        input logic ovf);
        logic r;
        case (op)
            CMP_EQ:  r = eq;
            CMP_NE:  r = !eq;
            CMP_LTU: r = borrow;
            CMP_GEU: r = !borrow;
            CMP_LT:  r = sign ^ ovf;
            CMP_GE:  r = !(sign ^ ovf);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    idli_serial_cmp_m u_cmp (
        .clk    (i_pred_gck),
        .rst    (i_pred_rst),
        .en     (cmp_en),
        .first  (cmp_first),
        .last   (cmp_last),
        .a      (i_cmp_a),
        .b      (i_cmp_b),
        .eq     (cmp_eq),
        .borrow (cmp_borrow),
        .sign   (cmp_sign),
        .ovf    (cmp_ovf)
    );

    // Flush always beats start, whatever the state.
    assign launch = i_cmp_start && !i_flush;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dst_d     = dst_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        cmp_en    = 1'b0;
        cmp_first = 1'b0;
        cmp_last  = 1'b0;

        case (state_q)
            PC_CMP: begin
                if (i_flush) begin
                    state_d = PC_IDLE;
                    cnt_d   = '0;
                end else if (i_cmp_start) begin
                    // Restart: old compare dropped, this cycle is nibble 0.
                    state_d   = PC_CMP;
                    cnt_d     = CNT_W'(1);
                    op_d      = i_cmp_op;
                    dst_d     = i_cmp_dst;
                    cmp_en    = 1'b1;
                    cmp_first = 1'b1;
                end else begin
                    cmp_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cmp_last  = 1'b1;
                        state_d   = PC_WB;
                        cnt_d     = '0;
                        wr_data_d = cmp_result(op_q, cmp_eq, cmp_borrow,
                                               cmp_sign, cmp_ovf);
                        wr_en_d   = (dst_q != PREG_PT);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                // IDLE and WB both accept a new compare; the WB write is
                // already on the registered outputs and is not revoked.
                if (launch) begin
                    state_d   = PC_CMP;
                    cnt_d     = CNT_W'(1);
                    op_d      = i_cmp_op;
                    dst_d     = i_cmp_dst;
                    cmp_en    = 1'b1;
                    cmp_first = 1'b1;
                end else begin
                    state_d = PC_IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_pred_gck or posedge i_pred_rst) begin
        if (i_pred_rst) begin
            state_q   <= PC_IDLE;
            cnt_q     <= '0;
            op_q      <= CMP_EQ;
            dst_q     <= PREG_P0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_busy         = (state_q != PC_IDLE);
    assign o_pred_wr      = dst_q;
    assign o_pred_wr_en   = wr_en_q;
    assign o_pred_wr_data = wr_data_q;

    // Read path is zero latency; the file bypasses a same-cycle write.
    assign o_pred_rd = i_instr_pred;
    assign o_exec    = i_pred_rd_data ^ i_instr_inv;

endmodule

// File: tb/tb_idli_pred_ctrl_m.sv
module tb_idli_pred_ctrl_m;
    import idli_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    cmp_op_t    op_s;
    preg_t      dst_s;
    logic [3:0] a_s, b_s;
    logic       flush;
    preg_t      guard;
    logic       inv;
    logic       exec_o, busy_o, wr_en_o, wr_data_o, rd_data;
    preg_t      rd_o, wr_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    idli_pred_ctrl_m #(.NIBBLES(4)) dut (
        .i_pred_gck     (clk),
        .i_pred_rst     (rst),
        .i_cmp_start    (start),
        .i_cmp_op       (op_s),
        .i_cmp_dst      (dst_s),
        .i_cmp_a        (a_s),
        .i_cmp_b        (b_s),
        .i_flush        (flush),
        .i_instr_pred   (guard),
        .i_instr_inv    (inv),
        .o_exec         (exec_o),
        .o_busy         (busy_o),
        .o_pred_rd      (rd_o),
        .i_pred_rd_data (rd_data),
        .o_pred_wr      (wr_o),
        .o_pred_wr_en   (wr_en_o),
        .o_pred_wr_data (wr_data_o)
    );

    // Predicate file model: PT reads 1, same-cycle write is bypassed.
    logic pf [0:3];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pf[i] <= 1'b0;
        end else if (wr_en_o) begin
            pf[wr_o] <= wr_data_o;
        end
    end
    always_comb begin
        rd_data = pf[rd_o];
        if (rd_o == PREG_PT) rd_data = 1'b1;
        else if (wr_en_o && wr_o == rd_o) rd_data = wr_data_o;
    end

    function automatic logic [3:0] nib(input logic [15:0] w, input int k);
        logic [3:0] r;
        r = 4'h0;
        if (k >= 0 && k < 4) r = w[4*k +: 4];
        return r;
    endfunction

    // Drive one cycle's inputs just after the edge, then sit on the negedge.
    task automatic cyc(input logic s, input cmp_op_t o, input preg_t d,
                       input logic [3:0] na, input logic [3:0] nb, input logic fl);
        @(posedge clk);
        #1;
        start = s; op_s = o; dst_s = d; a_s = na; b_s = nb; flush = fl;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_s = CMP_EQ; dst_s = PREG_P0;
        a_s = 4'h0; b_s = 4'h0; flush = 1'b0; guard = PREG_P0; inv = 1'b0;
        #12;
        n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_total++; if (wr_en_o !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en_o); else n_pass++;
        n_total++; if (wr_o !== PREG_P0) $display("FAIL reset_wr_sel: got %0d want 0", wr_o); else n_pass++;
        n_total++; if (wr_data_o !== 1'b0) $display("FAIL reset_wr_data: got %b want 0", wr_data_o); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ltu();
        for (int c = 0; c < 6; c++) begin
            cyc(c == 0, CMP_LTU, PREG_P1, nib(16'h0003, c), nib(16'h0010, c), 1'b0);
            n_total++; if (busy_o !== (c >= 1 && c <= 4)) $display("FAIL ltu_busy c%0d: got %b want %b", c, busy_o, (c >= 1 && c <= 4)); else n_pass++;
            n_total++; if (wr_en_o !== (c == 4)) $display("FAIL ltu_wr_en c%0d: got %b want %b", c, wr_en_o, (c == 4)); else n_pass++;
            if (c == 4) begin
                n_total++; if (wr_o !== PREG_P1) $display("FAIL ltu_wr_sel: got %0d want 1", wr_o); else n_pass++;
                n_total++; if (wr_data_o !== 1'b1) $display("FAIL ltu_wr_data: got %b want 1", wr_data_o); else n_pass++;
            end
        end
    endtask

    typedef struct {
        cmp_op_t     op;
        logic [15:0] a;
        logic [15:0] b;
        logic        exp;
    } vec_t;

    task automatic test_ops();
        vec_t v [12];
        v[0]  = '{CMP_LT,   16'h8000, 16'h0001, 1'b1};
        v[1]  = '{CMP_GEU,  16'h8000, 16'h0001, 1'b1};
        v[2]  = '{CMP_EQ,   16'hBEEF, 16'hBEEF, 1'b1};
        v[3]  = '{CMP_NE,   16'hBEEF, 16'hBEEF, 1'b0};
        v[4]  = '{CMP_LT,   16'h0001, 16'h8000, 1'b0};
        v[5]  = '{CMP_GE,   16'h0001, 16'h8000, 1'b1};
        v[6]  = '{CMP_LTU,  16'h0100, 16'h00FF, 1'b0};
        v[7]  = '{CMP_GEU,  16'h00FF, 16'h0100, 1'b0};
        v[8]  = '{CMP_EQ,   16'hBEEF, 16'hBEFF, 1'b0};
        v[9]  = '{CMP_RSV6, 16'h0000, 16'h0000, 1'b0};
        v[10] = '{CMP_LT,   16'hFFFF, 16'h0000, 1'b1};
        v[11] = '{CMP_NE,   16'h1230, 16'h1234, 1'b1};
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < 5; c++) begin
                cyc(c == 0, v[i].op, PREG_P0, nib(v[i].a, c), nib(v[i].b, c), 1'b0);
                if (c == 4) begin
                    n_total++; if (wr_en_o !== 1'b1) $display("FAIL ops%0d_wr_en: got %b want 1", i, wr_en_o); else n_pass++;
                    n_total++; if (wr_data_o !== v[i].exp) $display("FAIL ops%0d_wr_data: got %b want %b", i, wr_data_o, v[i].exp); else n_pass++;
                end
            end
        end
        cyc(1'b0, CMP_EQ, PREG_P0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic test_pt();
        guard = PREG_PT; inv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc(c == 0, CMP_EQ, PREG_PT, nib(16'h1111, c), nib(16'h1111, c), 1'b0);
            n_total++; if (wr_en_o !== 1'b0) $display("FAIL pt_wr_en c%0d: got %b want 0", c, wr_en_o); else n_pass++;
            n_total++; if (exec_o !== 1'b1) $display("FAIL pt_exec c%0d: got %b want 1", c, exec_o); else n_pass++;
            if (c == 5) begin
                n_total++; if (busy_o !== 1'b0) $display("FAIL pt_idle: got %b want 0", busy_o); else n_pass++;
            end
        end
        inv = 1'b1;
        #1;
        n_total++; if (exec_o !== 1'b0) $display("FAIL pt_exec_inv: got %b want 0", exec_o); else n_pass++;
    endtask

    task automatic test_bypass();
        guard = PREG_P2; inv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc(c == 0, CMP_EQ, PREG_P2, nib(16'h1234, c), nib(16'h1234, c), 1'b0);
            n_total++; if (exec_o !== (c >= 4)) $display("FAIL bypass_exec c%0d: got %b want %b", c, exec_o, (c >= 4)); else n_pass++;
        end
        // P2 now holds 1; write 0 into it with the guard inverted.
        inv = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc(c == 0, CMP_NE, PREG_P2, nib(16'h1234, c), nib(16'h1234, c), 1'b0);
            n_total++; if (exec_o !== (c >= 4)) $display("FAIL bypass_inv_exec c%0d: got %b want %b", c, exec_o, (c >= 4)); else n_pass++;
        end
        guard = PREG_P0; inv = 1'b0;
    endtask

    task automatic test_flush();
        for (int c = 0; c < 7; c++) begin
            cyc(c == 0, CMP_LTU, PREG_P0, nib(16'h0003, c), nib(16'h0010, c), c == 2);
            n_total++; if (wr_en_o !== 1'b0) $display("FAIL flush_wr_en c%0d: got %b want 0", c, wr_en_o); else n_pass++;
            if (c == 2 || c == 3) begin
                n_total++; if (busy_o !== (c == 2)) $display("FAIL flush_busy c%0d: got %b want %b", c, busy_o, (c == 2)); else n_pass++;
            end
        end
        // Start and flush together in IDLE: start is ignored.
        cyc(1'b1, CMP_EQ, PREG_P0, 4'h0, 4'h0, 1'b1);
        for (int c = 1; c < 6; c++) begin
            cyc(1'b0, CMP_EQ, PREG_P0, 4'h0, 4'h0, 1'b0);
            n_total++; if (busy_o !== 1'b0 || wr_en_o !== 1'b0) $display("FAIL flush_start c%0d: got busy %b wr_en %b want 0 0", c, busy_o, wr_en_o); else n_pass++;
        end
    endtask

    task automatic test_restart();
        for (int c = 0; c < 8; c++) begin
            if (c < 2) cyc(c == 0, CMP_LTU, PREG_P0, nib(16'h0003, c), nib(16'h0010, c), 1'b0);
            else       cyc(c == 2, CMP_EQ, PREG_P1, nib(16'h1234, c - 2), nib(16'h1235, c - 2), 1'b0);
            n_total++; if (wr_en_o !== (c == 6)) $display("FAIL restart_wr_en c%0d: got %b want %b", c, wr_en_o, (c == 6)); else n_pass++;
            if (c == 6) begin
                n_total++; if (wr_o !== PREG_P1) $display("FAIL restart_wr_sel: got %0d want 1", wr_o); else n_pass++;
                n_total++; if (wr_data_o !== 1'b0) $display("FAIL restart_wr_data: got %b want 0", wr_data_o); else n_pass++;
            end
        end
    endtask

    task automatic test_wb_flush();
        for (int c = 0; c < 6; c++) begin
            cyc(c == 0, CMP_EQ, PREG_P1, nib(16'h5555, c), nib(16'h5555, c), c == 4);
            if (c == 4) begin
                n_total++; if (wr_en_o !== 1'b1) $display("FAIL wbflush_wr_en: got %b want 1", wr_en_o); else n_pass++;
                n_total++; if (wr_data_o !== 1'b1) $display("FAIL wbflush_wr_data: got %b want 1", wr_data_o); else n_pass++;
            end
            if (c == 5) begin
                n_total++; if (busy_o !== 1'b0) $display("FAIL wbflush_idle: got %b want 0", busy_o); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            if (c < 4) cyc(c == 0, CMP_LTU, PREG_P0, nib(16'h0003, c), nib(16'h0010, c), 1'b0);
            else       cyc(c == 4, CMP_GEU, PREG_P1, nib(16'h0003, c - 4), nib(16'h0010, c - 4), 1'b0);
            n_total++; if (wr_en_o !== (c == 4 || c == 8)) $display("FAIL b2b_wr_en c%0d: got %b want %b", c, wr_en_o, (c == 4 || c == 8)); else n_pass++;
            n_total++; if (busy_o !== (c >= 1 && c <= 8)) $display("FAIL b2b_busy c%0d: got %b want %b", c, busy_o, (c >= 1 && c <= 8)); else n_pass++;
            if (c == 4) begin
                n_total++; if (wr_o !== PREG_P0 || wr_data_o !== 1'b1) $display("FAIL b2b_first: got sel %0d data %b want 0 1", wr_o, wr_data_o); else n_pass++;
            end
            if (c == 8) begin
                n_total++; if (wr_o !== PREG_P1 || wr_data_o !== 1'b0) $display("FAIL b2b_second: got sel %0d data %b want 1 0", wr_o, wr_data_o); else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b1, CMP_EQ, PREG_P1, 4'h7, 4'h7, 1'b0);
        cyc(1'b0, CMP_EQ, PREG_P1, 4'h7, 4'h7, 1'b0);
        @(posedge clk);
        #1;
        a_s = 4'h7; b_s = 4'h7;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy_o); else n_pass++;
        n_total++; if (wr_en_o !== 1'b0) $display("FAIL arst_wr_en: got %b want 0", wr_en_o); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, CMP_EQ, PREG_P1, 4'h7, 4'h7, 1'b0);
            n_total++; if (wr_en_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL arst_after c%0d: got wr_en %b busy %b want 0 0", c, wr_en_o, busy_o); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ltu();
        test_ops();
        test_pt();
        test_bypass();
        test_flush();
        test_restart();
        test_wb_flush();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
